beep_scheduler: RTL and testbench

//  Shares the single buzzer between three alarm sources (key-press ack, high-PM2.5 alarm,

---
 rtl/beep_scheduler_if.sv | 28 ++
 rtl/beep_scheduler.sv | 134 +++++++++++++
 tb/tb_beep_scheduler.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/beep_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : beep_scheduler_if
// Purpose  : Request/tone bundle between the alarm sources and the buzzer
//            scheduler. The master side drives tick/mute/requests, the slave
//            side (the scheduler) drives the buzzer and status outputs.
// Revision : 1.0 - initial release
// ============================================================================
interface beep_scheduler_if;
  logic       tick_1k;
  logic       mute;
  logic [2:0] req;
  logic       buzzer;
  logic       busy;
  logic [1:0] active_id;
  logic       done;

  modport master (
    output tick_1k, mute, req,
    input  buzzer, busy, active_id, done
  );

  modport slave (
    input  tick_1k, mute, req,
    output buzzer, busy, active_id, done
  );
endinterface
`default_nettype wire

// File: rtl/beep_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : beep_scheduler
// Purpose  : Shares one buzzer between three alarm sources. Requests are
//            latched as pending and granted in fixed priority (lowest index
//            first, non-preemptive); source i plays i+1 beeps of BEEP_MS tone
//            followed by GAP_MS silence each, timed by the 1 kHz tick.
// Revision : 1.0 - initial release
// ============================================================================
module beep_scheduler #(
  parameter int BEEP_MS = 100,
  parameter int GAP_MS  = 100
) (
  input wire              clk,
  input wire              rst_n,
  beep_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BEEP = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [15:0] c_beep_last = 16'(BEEP_MS - 1);
  localparam logic [15:0] c_gap_last  = 16'(GAP_MS - 1);

  state_t      r_state;
  logic [2:0]  r_pending;
  logic [15:0] r_ms_cnt;
  logic [1:0]  r_beeps_left;
  logic        r_buzzer;
  logic        r_busy;
  logic [1:0]  r_active_id;
  logic        r_done;

  logic [1:0]  w_winner;
  logic        w_grant;
  logic [2:0]  w_grant_mask;

  // Fixed-priority pick of the pending source: lowest index wins.
  always_comb begin
    w_winner = 2'd0;
    if (r_pending[0])      w_winner = 2'd0;
    else if (r_pending[1]) w_winner = 2'd1;
    else if (r_pending[2]) w_winner = 2'd2;
  end

  // A grant happens only from IDLE; the granted bit is cleared unless a new
  // request for the same source arrives on the grant cycle (set wins).
  assign w_grant      = (r_state == ST_IDLE) && (r_pending != 3'b000) && !bus.mute;
  assign w_grant_mask = w_grant ? (3'b001 << w_winner) : 3'b000;

  // Scheduler state machine with registered outputs; mute aborts from any state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_pending    <= 3'b000;
      r_ms_cnt     <= 16'd0;
      r_beeps_left <= 2'd0;
      r_buzzer     <= 1'b0;
      r_busy       <= 1'b0;
      r_active_id  <= 2'd0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.mute) begin
        r_state      <= ST_IDLE;
        r_pending    <= 3'b000;
        r_ms_cnt     <= 16'd0;
        r_beeps_left <= 2'd0;
        r_buzzer     <= 1'b0;
        r_busy       <= 1'b0;
        r_active_id  <= 2'd0;
      end else begin
        r_pending <= (r_pending & ~w_grant_mask) | bus.req;
        unique case (r_state)
          ST_IDLE: begin
            if (w_grant) begin
              r_state      <= ST_BEEP;
              r_active_id  <= w_winner;
              r_beeps_left <= w_winner + 2'd1;
              r_ms_cnt     <= 16'd0;
              r_busy       <= 1'b1;
              r_buzzer     <= 1'b0;
            end
          end
          ST_BEEP: begin
            if (bus.tick_1k) begin
              if (r_ms_cnt == c_beep_last) begin
                // Tone always ends low so the gap starts silent.
                r_state  <= ST_GAP;
                r_ms_cnt <= 16'd0;
                r_buzzer <= 1'b0;
              end else begin
                r_ms_cnt <= r_ms_cnt + 16'd1;
                r_buzzer <= ~r_buzzer;
              end
            end
          end
          ST_GAP: begin
            r_buzzer <= 1'b0;
            if (bus.tick_1k) begin
              if (r_ms_cnt == c_gap_last) begin
                r_ms_cnt     <= 16'd0;
                r_beeps_left <= r_beeps_left - 2'd1;
                if (r_beeps_left == 2'd1) begin
                  r_state     <= ST_IDLE;
                  r_done      <= 1'b1;
                  r_busy      <= 1'b0;
                  r_active_id <= 2'd0;
                end else begin
                  r_state <= ST_BEEP;
                end
              end else begin
                r_ms_cnt <= r_ms_cnt + 16'd1;
              end
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.buzzer    = r_buzzer;
  assign bus.busy      = r_busy;
  assign bus.active_id = r_active_id;
  assign bus.done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_beep_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_beep_scheduler
// Purpose  : Self-checking bench for beep_scheduler. A pattern-level model
//            (pending set, tick count since grant) predicts buzzer, busy,
//            active_id and done every clock.
// Revision : 1.0 - initial release
// ============================================================================
module tb_beep_scheduler;
  localparam int BEEP_MS = 3;
  localparam int GAP_MS  = 2;
  localparam int PERIOD  = BEEP_MS + GAP_MS;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  beep_scheduler_if bus();

  beep_scheduler #(.BEEP_MS(BEEP_MS), .GAP_MS(GAP_MS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int    total = 0;
  int    bad   = 0;
  int    tick_phase = 0;
  string cur_tag = "reset";

  // Pattern-level reference state
  logic [2:0] m_pending;
  logic       m_busy;
  logic       m_buzzer;
  logic       m_done;
  logic [1:0] m_id;
  int         m_ticks;

  task automatic model_reset();
    m_pending = 3'b000;
    m_busy    = 1'b0;
    m_buzzer  = 1'b0;
    m_done    = 1'b0;
    m_id      = 2'd0;
    m_ticks   = 0;
  endtask

  function automatic logic [1:0] lowest(input logic [2:0] p);
    if (p[0]) return 2'd0;
    if (p[1]) return 2'd1;
    return 2'd2;
  endfunction

  // One clock of the reference: a pattern is (id+1) periods of ticks long;
  // within a period the first BEEP_MS-1 ticks toggle the tone, the rest are silent.
  task automatic model_clock();
    logic [1:0] w;
    int pos;
    m_done = 1'b0;
    if (bus.mute) begin
      m_pending = 3'b000;
      m_busy    = 1'b0;
      m_id      = 2'd0;
      m_buzzer  = 1'b0;
      m_ticks   = 0;
    end else begin
      if (!m_busy) begin
        if (m_pending != 3'b000) begin
          w            = lowest(m_pending);
          m_pending[w] = 1'b0;
          m_busy       = 1'b1;
          m_id         = w;
          m_ticks      = 0;
          m_buzzer     = 1'b0;
        end
      end else if (bus.tick_1k) begin
        m_ticks  = m_ticks + 1;
        pos      = (m_ticks - 1) % PERIOD;
        m_buzzer = (pos < BEEP_MS - 1) ? ((pos % 2) == 0) : 1'b0;
        if (m_ticks == (int'(m_id) + 1) * PERIOD) begin
          m_busy   = 1'b0;
          m_id     = 2'd0;
          m_done   = 1'b1;
          m_buzzer = 1'b0;
        end
      end
      m_pending = m_pending | bus.req;
    end
  endtask

  task automatic check();
    total++;
    assert ({bus.buzzer, bus.busy, bus.active_id, bus.done} === {m_buzzer, m_busy, m_id, m_done})
    else begin
      bad++;
      $error("FAIL %s: observed buzzer,busy,id,done=%b,%b,%0d,%b expected=%b,%b,%0d,%b",
             cur_tag, bus.buzzer, bus.busy, bus.active_id, bus.done,
             m_buzzer, m_busy, m_id, m_done);
    end
  endtask

  // Drive inputs after a negedge, advance one clock, check on the next negedge.
  task automatic cycle(input logic [2:0] r, input logic m);
    bus.req     = r;
    bus.mute    = m;
    bus.tick_1k = (tick_phase == 3);
    tick_phase  = (tick_phase + 1) % 4;
    @(posedge clk);
    if (rst_n) model_clock();
    @(negedge clk);
    check();
  endtask

  task automatic run(input int n);
    repeat (n) cycle(3'b000, 1'b0);
  endtask

  function automatic logic model_in_gap();
    return m_busy && (m_ticks > 0) && (((m_ticks - 1) % PERIOD) >= BEEP_MS - 1);
  endfunction

  initial begin
    bus.req     = 3'b000;
    bus.mute    = 1'b0;
    bus.tick_1k = 1'b0;
    model_reset();

    // Reset state
    #12;
    check();
    @(negedge clk);
    rst_n = 1'b1;

    // Single key ack
    cur_tag = "s1_key";
    cycle(3'b001, 1'b0);
    run(30);

    // Filter reminder: three beeps
    cur_tag = "s2_filter";
    cycle(3'b100, 1'b0);
    run(70);

    // Simultaneous PM and filter: PM first, filter right after done
    cur_tag = "s3_prio";
    cycle(3'b110, 1'b0);
    run(110);

    // Key ack during filter pattern waits for it to finish
    cur_tag = "s4_nopreempt";
    cycle(3'b100, 1'b0);
    run(20);
    cycle(3'b001, 1'b0);
    run(90);

    // Mute mid-BEEP of source 1 with source 2 pending
    cur_tag = "s5_mute";
    cycle(3'b110, 1'b0);
    run(5);
    cycle(3'b000, 1'b1);
    cycle(3'b100, 1'b1);
    run(40);

    // Async reset in the middle of a gap
    cur_tag = "s6_reset";
    cycle(3'b001, 1'b0);
    for (int k = 0; k < 100 && !model_in_gap(); k++) cycle(3'b000, 1'b0);
    total++;
    assert (model_in_gap())
    else begin
      bad++;
      $error("FAIL s6_gap_wait: observed in_gap=%b expected=1", model_in_gap());
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    cur_tag = "s6_async_zero";
    check();
    @(negedge clk);
    check();
    rst_n = 1'b1;
    cur_tag = "s6_after";
    cycle(3'b001, 1'b0);
    run(30);

    // Random traffic with occasional mute pulses
    cur_tag = "random";
    for (int k = 0; k < 800; k++) begin
      logic [2:0] r;
      logic       m;
      r[0] = ($urandom_range(0, 19) == 0);
      r[1] = ($urandom_range(0, 29) == 0);
      r[2] = ($urandom_range(0, 39) == 0);
      m    = ($urandom_range(0, 99) == 0);
      cycle(r, m);
    end
    run(80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
